// File: rtl/pixel_frame_sequencer_pkg.sv
// Shared types and defaults for the pixel frame sequencer.
// No logic: state enum plus default array geometry.
package pixel_frame_sequencer_pkg;

  localparam int DEF_PIXEL_BITS        = 8;
  localparam int DEF_PIXEL_ARRAY_WIDTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READ,
    ST_HANDOFF
  } sequencer_state_t;

endpackage

// File: rtl/pixel_frame_sequencer_phase_timer.sv
// Load/count-down phase timer; done is high while the count is zero.
// A phase of length L loads L-1 on entry and ends in the cycle done is seen.
module pixel_frame_sequencer_phase_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Frame sequencer ERASE -> EXPOSE -> CONVERT -> per-row READ/HANDOFF; all outputs registered (Moore).
// Each row costs READ_CYCLES+1 cycles with out_ready high; out_ready low holds the captured row stable.
module pixel_frame_sequencer
  import pixel_frame_sequencer_pkg::*;
#(
  parameter int  NUM_ROWS    = 4,
  parameter int  NUM_COLS    = DEF_PIXEL_ARRAY_WIDTH,
  parameter int  PIXEL_BITS  = DEF_PIXEL_BITS,
  parameter int  TIMER_W     = 16,
  parameter int  READ_CYCLES = 2,
  localparam int ROW_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int DATA_W      = NUM_COLS * PIXEL_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  continuous,
  input  logic [TIMER_W-1:0]    erase_cycles,
  input  logic [TIMER_W-1:0]    expose_cycles,
  input  logic [DATA_W-1:0]     row_data_in,
  output logic                  erase,
  output logic                  expose,
  output logic                  convert,
  output logic                  read,
  output logic [ROW_W-1:0]      row_sel,
  output logic [PIXEL_BITS-1:0] pixel_counter,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [ROW_W-1:0]      out_row,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int                 RC_W      = $clog2(READ_CYCLES + 1);
  localparam logic [TIMER_W-1:0] CONV_LOAD = TIMER_W'((1 << PIXEL_BITS) - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(NUM_ROWS - 1);
  localparam logic [RC_W-1:0]    READ_LAST = RC_W'(READ_CYCLES - 1);

  sequencer_state_t   state, next_state;
  logic [TIMER_W-1:0] expose_lat;
  logic [TIMER_W-1:0] timer_load_val;
  logic               timer_load, timer_done;
  logic [RC_W-1:0]    read_cnt;
  logic               read_last, handshake, last_row;

  // Zero-length phases are stretched to one cycle.
  function automatic logic [TIMER_W-1:0] len_to_load(input logic [TIMER_W-1:0] n);
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

  assign read_last = (read_cnt == READ_LAST);
  assign handshake = out_valid && out_ready;
  assign last_row  = (row_sel == LAST_ROW);

  pixel_frame_sequencer_phase_timer #(.TIMER_W(TIMER_W)) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .done     (timer_done)
  );

  always_comb begin
    next_state     = state;
    timer_load     = 1'b0;
    timer_load_val = '0;
    case (state)
      ST_IDLE:    if (start) next_state = ST_ERASE;
      ST_ERASE:   if (timer_done) next_state = ST_EXPOSE;
      ST_EXPOSE:  if (timer_done) next_state = ST_CONVERT;
      ST_CONVERT: if (timer_done) next_state = ST_READ;
      ST_READ:    if (read_last) next_state = ST_HANDOFF;
      ST_HANDOFF: begin
        // The frame_done cycle is spent in HANDOFF with out_valid already low.
        if (frame_done) next_state = continuous ? ST_ERASE : ST_IDLE;
        else if (handshake && !last_row) next_state = ST_READ;
      end
      default:    next_state = ST_IDLE;
    endcase
    if (abort) next_state = ST_IDLE;

    if (next_state != state) begin
      case (next_state)
        ST_ERASE: begin
          timer_load     = 1'b1;
          timer_load_val = len_to_load(erase_cycles);
        end
        ST_EXPOSE: begin
          timer_load     = 1'b1;
          timer_load_val = len_to_load(expose_lat);
        end
        ST_CONVERT: begin
          timer_load     = 1'b1;
          timer_load_val = CONV_LOAD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      expose_lat    <= '0;
      read_cnt      <= '0;
      erase         <= 1'b0;
      expose        <= 1'b0;
      convert       <= 1'b0;
      read          <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_row       <= '0;
      row_sel       <= '0;
      pixel_counter <= '0;
    end else begin
      state         <= next_state;
      erase         <= (next_state == ST_ERASE);
      expose        <= (next_state == ST_EXPOSE);
      convert       <= (next_state == ST_CONVERT);
      read          <= (next_state == ST_READ);
      busy          <= (next_state != ST_IDLE);
      pixel_counter <= (state == ST_CONVERT && next_state == ST_CONVERT) ? pixel_counter + 1'b1 : '0;
      read_cnt      <= (state == ST_READ && next_state == ST_READ) ? read_cnt + 1'b1 : '0;
      frame_done    <= (state == ST_HANDOFF) && handshake && last_row && !abort;

      if (next_state == ST_ERASE && state != ST_ERASE) expose_lat <= expose_cycles;

      if (abort) begin
        out_valid <= 1'b0;
      end else if (state == ST_READ && read_last) begin
        out_valid <= 1'b1;
        out_data  <= row_data_in;
        out_row   <= row_sel;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end

      if (next_state == ST_READ) begin
        if (state == ST_HANDOFF) row_sel <= row_sel + 1'b1;
      end else if (next_state != ST_HANDOFF) begin
        row_sel <= '0;
      end
    end
  end

endmodule
